data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 104 ++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Data memory responder: 2^ADDR_WIDTH x 32-bit word store with byte-lane writes; optional wait states under DMEM_WAITSTATE_EN.
// Latency: request accepted at edge T -> DataMem_Ready/MReadData in the cycle after edge T+1+W (W=WAIT_CYCLES, or 0 without the macro).
// Backpressure: none; inputs are ignored while BUSY/ACK, and a new request may be presented during the Ready cycle.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] MWriteData,
    input  logic [3:0]  WriteEnable,
    input  logic        ReadEnable,
    output logic [31:0] MReadData,
    output logic        DataMem_Ready
);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [31:0]             lat_wdat;
    logic [3:0]              lat_we;
    logic                    lat_re;
    logic [31:0]             mem [0:(1 << ADDR_WIDTH)-1];
    logic                    req;

    assign req = ReadEnable | (|WriteEnable);

    // Byte-offset and above-depth address bits are deliberately ignored (wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{Address[31:ADDR_WIDTH+2], Address[1:0]};

`ifdef DMEM_WAITSTATE_EN
    logic [3:0] wait_cnt;
`else
    logic [3:0] unused_wait;
    assign unused_wait = 4'(WAIT_CYCLES);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            DataMem_Ready <= 1'b0;
            MReadData     <= 32'h0000_0000;
`ifdef DMEM_WAITSTATE_EN
            wait_cnt      <= 4'd0;
`endif
        end else begin
            DataMem_Ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_addr <= Address[ADDR_WIDTH+1:2];
                        lat_wdat <= MWriteData;
                        lat_we   <= WriteEnable;
                        lat_re   <= ReadEnable;
`ifdef DMEM_WAITSTATE_EN
                        if (WAIT_CYCLES == 0) begin
                            state <= ACK;
                        end else begin
                            state    <= BUSY;
                            wait_cnt <= 4'(WAIT_CYCLES);
                        end
`else
                        state <= ACK;
`endif
                    end
                end
                BUSY: begin
`ifdef DMEM_WAITSTATE_EN
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) begin
                        state <= ACK;
                    end
`else
                    state <= IDLE;
`endif
                end
                ACK: begin
                    // Ready and read data are registered here, so they appear one cycle after ACK.
                    DataMem_Ready <= 1'b1;
                    if (lat_re) begin
                        MReadData <= mem[lat_addr];
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write commits on the edge leaving ACK; reset on that edge cancels it.
    always_ff @(posedge clock) begin
        if (!reset && state == ACK) begin
            for (int b = 0; b < 4; b++) begin
                if (lat_we[b]) begin
                    mem[lat_addr][8*b +: 8] <= lat_wdat[8*b +: 8];
                end
            end
        end
    end

endmodule
